// File: rtl/regfile_wb_sched_if.sv
// regfile_wb_sched_if: bundle of the issue, ALU/LSU writeback handshakes and register-file write port
// Ports: master = execute/decode side driving requests; slave = the scheduler answering them.
interface regfile_wb_sched_if;
  logic        iss_valid_i;
  logic [4:0]  iss_rd_i;
  logic [4:0]  iss_rs1_i;
  logic [4:0]  iss_rs2_i;
  logic        stall_o;
  logic        alu_valid_i;
  logic [4:0]  alu_rd_i;
  logic [31:0] alu_dat_i;
  logic        alu_ready_o;
  logic        lsu_valid_i;
  logic [4:0]  lsu_rd_i;
  logic [31:0] lsu_dat_i;
  logic        lsu_ready_o;
  logic        wr_en_o;
  logic [4:0]  reg_des_o;
  logic [31:0] reg_des_dat_o;
  logic [31:0] busy_o;
  modport master (
    output iss_valid_i, iss_rd_i, iss_rs1_i, iss_rs2_i,
    output alu_valid_i, alu_rd_i, alu_dat_i, lsu_valid_i, lsu_rd_i, lsu_dat_i,
    input  stall_o, alu_ready_o, lsu_ready_o, wr_en_o, reg_des_o, reg_des_dat_o, busy_o
  );
  modport slave (
    input  iss_valid_i, iss_rd_i, iss_rs1_i, iss_rs2_i,
    input  alu_valid_i, alu_rd_i, alu_dat_i, lsu_valid_i, lsu_rd_i, lsu_dat_i,
    output stall_o, alu_ready_o, lsu_ready_o, wr_en_o, reg_des_o, reg_des_dat_o, busy_o
  );
endinterface

// File: rtl/regfile_wb_sched.sv
// regfile_wb_sched: round-robin ALU/LSU writeback arbiter with RAW/WAW scoreboard
// Ports: clk_i clock; rst_n_i async active-low reset; bus (slave) carries decode issue/stall,
// ALU and LSU writeback handshakes, the registered register-file write port and busy scoreboard.
module regfile_wb_sched #(
  parameter int ALU_FIRST = 1,
  parameter int CHECK_WAW = 1
) (
  input logic               clk_i,
  input logic               rst_n_i,
  regfile_wb_sched_if.slave bus
);
  logic        prio_alu, grant_alu, grant_lsu, grant, stall, set, wr_en;
  logic [4:0]  g_rd, des;
  logic [31:0] g_dat, dat, busy, busy_nxt;
  always_comb begin
    grant_alu = bus.alu_valid_i && (!bus.lsu_valid_i || prio_alu);
    grant_lsu = bus.lsu_valid_i && !grant_alu;
    grant     = grant_alu || grant_lsu;
    g_rd      = grant_alu ? bus.alu_rd_i : bus.lsu_rd_i;
    g_dat     = grant_alu ? bus.alu_dat_i : bus.lsu_dat_i;
    // busy[0] is never set, so x0 operands can never match
    stall     = bus.iss_valid_i && (busy[bus.iss_rs1_i] || busy[bus.iss_rs2_i] ||
                (CHECK_WAW != 0 && busy[bus.iss_rd_i]));
    set       = bus.iss_valid_i && !stall && bus.iss_rd_i != 5'd0;
    // clear first, then set: a new issue reserves the register after the older write
    busy_nxt  = busy & ~(grant ? 32'd1 << g_rd : 32'd0);
    busy_nxt  = set ? busy_nxt | (32'd1 << bus.iss_rd_i) : busy_nxt;
  end
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      busy     <= '0;
      wr_en    <= 1'b0;
      des      <= '0;
      dat      <= '0;
      prio_alu <= (ALU_FIRST != 0);
    end else begin
      busy  <= busy_nxt;
      wr_en <= grant && g_rd != 5'd0;
      if (grant) begin
        des      <= g_rd;
        dat      <= g_dat;
        prio_alu <= grant_lsu;
      end
    end
  end
  assign bus.stall_o       = stall;
  assign bus.alu_ready_o   = grant_alu;
  assign bus.lsu_ready_o   = grant_lsu;
  assign bus.wr_en_o       = wr_en;
  assign bus.reg_des_o     = des;
  assign bus.reg_des_dat_o = dat;
  assign bus.busy_o        = busy;
endmodule

// File: tb/tb_regfile_wb_sched.sv
// tb_regfile_wb_sched: directed and randomized checks of regfile_wb_sched against a behavioural model
module tb_regfile_wb_sched;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_chk = 0;
  int   n_fail = 0;
  always #5 clk = ~clk;
  regfile_wb_sched_if a ();
  regfile_wb_sched_if b ();
  assign b.iss_valid_i = a.iss_valid_i;
  assign b.iss_rd_i    = a.iss_rd_i;
  assign b.iss_rs1_i   = a.iss_rs1_i;
  assign b.iss_rs2_i   = a.iss_rs2_i;
  assign b.alu_valid_i = a.alu_valid_i;
  assign b.alu_rd_i    = a.alu_rd_i;
  assign b.alu_dat_i   = a.alu_dat_i;
  assign b.lsu_valid_i = a.lsu_valid_i;
  assign b.lsu_rd_i    = a.lsu_rd_i;
  assign b.lsu_dat_i   = a.lsu_dat_i;
  regfile_wb_sched dut_a (.clk_i(clk), .rst_n_i(rst_n), .bus(a.slave));
  regfile_wb_sched #(.ALU_FIRST(0), .CHECK_WAW(0)) dut_b (.clk_i(clk), .rst_n_i(rst_n), .bus(b.slave));

  task tick;
    @(posedge clk);
    #1;
  endtask

  task idle;
    a.iss_valid_i = 0; a.iss_rd_i = 0; a.iss_rs1_i = 0; a.iss_rs2_i = 0;
    a.alu_valid_i = 0; a.alu_rd_i = 0; a.alu_dat_i = 0;
    a.lsu_valid_i = 0; a.lsu_rd_i = 0; a.lsu_dat_i = 0;
  endtask

  task do_reset;
    idle;
    rst_n = 0;
    tick;
    rst_n = 1;
    tick;
  endtask

  task test_reset;
    idle;
    tick;
    tick;
    rst_n = 1;
    tick;
    n_chk++; if (a.busy_o !== 32'd0) begin n_fail++; $display("FAIL reset_busy: got %h want 0", a.busy_o); end
    n_chk++; if (a.wr_en_o !== 1'b0) begin n_fail++; $display("FAIL reset_wr_en: got %b want 0", a.wr_en_o); end
    n_chk++; if (a.reg_des_o !== 5'd0) begin n_fail++; $display("FAIL reset_des: got %0d want 0", a.reg_des_o); end
    n_chk++; if (a.reg_des_dat_o !== 32'd0) begin n_fail++; $display("FAIL reset_dat: got %h want 0", a.reg_des_dat_o); end
    n_chk++; if ({a.stall_o, a.alu_ready_o, a.lsu_ready_o} !== 3'b000) begin n_fail++; $display("FAIL reset_comb: got %b want 000", {a.stall_o, a.alu_ready_o, a.lsu_ready_o}); end
    a.iss_valid_i = 1; a.iss_rd_i = 5;
    a.alu_valid_i = 1; a.alu_rd_i = 6; a.alu_dat_i = 32'h66;
    tick;
    idle;
    n_chk++; if (a.busy_o !== 32'h20) begin n_fail++; $display("FAIL reset_pre_busy: got %h want 00000020", a.busy_o); end
    n_chk++; if (a.wr_en_o !== 1'b1) begin n_fail++; $display("FAIL reset_pre_wr: got %b want 1", a.wr_en_o); end
    #2 rst_n = 0;
    #1;
    n_chk++; if (a.busy_o !== 32'd0) begin n_fail++; $display("FAIL reset_async_busy: got %h want 0", a.busy_o); end
    n_chk++; if (a.wr_en_o !== 1'b0) begin n_fail++; $display("FAIL reset_async_wr: got %b want 0", a.wr_en_o); end
    rst_n = 1;
    tick;
  endtask

  task test_single_alu;
    do_reset;
    a.alu_valid_i = 1; a.alu_rd_i = 5; a.alu_dat_i = 32'hDEADBEEF;
    #1;
    n_chk++; if ({a.alu_ready_o, a.lsu_ready_o} !== 2'b10) begin n_fail++; $display("FAIL single_ready: got %b want 10", {a.alu_ready_o, a.lsu_ready_o}); end
    tick;
    idle;
    n_chk++; if (a.wr_en_o !== 1'b1) begin n_fail++; $display("FAIL single_wr: got %b want 1", a.wr_en_o); end
    n_chk++; if (a.reg_des_o !== 5'd5) begin n_fail++; $display("FAIL single_des: got %0d want 5", a.reg_des_o); end
    n_chk++; if (a.reg_des_dat_o !== 32'hDEADBEEF) begin n_fail++; $display("FAIL single_dat: got %h want deadbeef", a.reg_des_dat_o); end
    tick;
    n_chk++; if (a.wr_en_o !== 1'b0) begin n_fail++; $display("FAIL single_wr_off: got %b want 0", a.wr_en_o); end
    n_chk++; if (a.reg_des_o !== 5'd5 || a.reg_des_dat_o !== 32'hDEADBEEF) begin n_fail++; $display("FAIL single_hold: got %0d/%h want 5/deadbeef", a.reg_des_o, a.reg_des_dat_o); end
  endtask

  task test_collision;
    do_reset;
    a.alu_valid_i = 1; a.alu_rd_i = 1; a.alu_dat_i = 32'h11;
    a.lsu_valid_i = 1; a.lsu_rd_i = 2; a.lsu_dat_i = 32'h22;
    for (int i = 0; i < 4; i++) begin
      #1;
      n_chk++; if ({a.alu_ready_o, a.lsu_ready_o} !== ((i % 2 == 0) ? 2'b10 : 2'b01)) begin n_fail++; $display("FAIL collide_ready%0d: got %b", i, {a.alu_ready_o, a.lsu_ready_o}); end
      tick;
      if (i == 3) idle;
      n_chk++; if (a.wr_en_o !== 1'b1 || a.reg_des_o !== ((i % 2 == 0) ? 5'd1 : 5'd2)) begin n_fail++; $display("FAIL collide_wr%0d: got en=%b des=%0d", i, a.wr_en_o, a.reg_des_o); end
    end
    tick;
    n_chk++; if (a.wr_en_o !== 1'b0) begin n_fail++; $display("FAIL collide_end: got %b want 0", a.wr_en_o); end
  endtask

  task test_raw;
    do_reset;
    a.iss_valid_i = 1; a.iss_rd_i = 7;
    #1;
    n_chk++; if (a.stall_o !== 1'b0) begin n_fail++; $display("FAIL raw_issue_stall: got %b want 0", a.stall_o); end
    tick;
    a.iss_rd_i = 8; a.iss_rs1_i = 7;
    #1;
    n_chk++; if (a.busy_o !== 32'h80) begin n_fail++; $display("FAIL raw_busy: got %h want 00000080", a.busy_o); end
    n_chk++; if (a.stall_o !== 1'b1) begin n_fail++; $display("FAIL raw_stall: got %b want 1", a.stall_o); end
    a.lsu_valid_i = 1; a.lsu_rd_i = 7; a.lsu_dat_i = 32'h77;
    #1;
    n_chk++; if (a.lsu_ready_o !== 1'b1) begin n_fail++; $display("FAIL raw_lsu_ready: got %b want 1", a.lsu_ready_o); end
    tick;
    a.lsu_valid_i = 0;
    #1;
    n_chk++; if (a.stall_o !== 1'b0) begin n_fail++; $display("FAIL raw_release: got %b want 0", a.stall_o); end
    n_chk++; if (a.wr_en_o !== 1'b1 || a.reg_des_o !== 5'd7 || a.reg_des_dat_o !== 32'h77) begin n_fail++; $display("FAIL raw_wr: got en=%b des=%0d dat=%h", a.wr_en_o, a.reg_des_o, a.reg_des_dat_o); end
    n_chk++; if (a.busy_o !== 32'd0) begin n_fail++; $display("FAIL raw_busy_clr: got %h want 0", a.busy_o); end
    idle;
    tick;
  endtask

  task test_x0_waw;
    do_reset;
    a.iss_valid_i = 1; a.iss_rd_i = 0;
    tick;
    n_chk++; if (a.busy_o !== 32'd0) begin n_fail++; $display("FAIL x0_issue: got %h want 0", a.busy_o); end
    a.iss_rd_i = 3;
    tick;
    n_chk++; if (a.busy_o !== 32'h8) begin n_fail++; $display("FAIL waw_busy: got %h want 00000008", a.busy_o); end
    n_chk++; if (a.stall_o !== 1'b1) begin n_fail++; $display("FAIL waw_stall: got %b want 1", a.stall_o); end
    n_chk++; if (b.stall_o !== 1'b0) begin n_fail++; $display("FAIL waw_off_stall: got %b want 0", b.stall_o); end
    a.iss_valid_i = 0;
    a.alu_valid_i = 1; a.alu_rd_i = 0; a.alu_dat_i = 32'h55;
    #1;
    n_chk++; if (a.alu_ready_o !== 1'b1) begin n_fail++; $display("FAIL x0_ready: got %b want 1", a.alu_ready_o); end
    tick;
    idle;
    n_chk++; if (a.wr_en_o !== 1'b0) begin n_fail++; $display("FAIL x0_wr: got %b want 0", a.wr_en_o); end
    n_chk++; if (a.busy_o !== 32'h8) begin n_fail++; $display("FAIL x0_busy: got %h want 00000008", a.busy_o); end
  endtask

  task test_race;
    do_reset;
    a.iss_valid_i = 1; a.iss_rd_i = 9;
    tick;
    n_chk++; if (b.busy_o !== 32'h200) begin n_fail++; $display("FAIL race_pre: got %h want 00000200", b.busy_o); end
    a.alu_valid_i = 1; a.alu_rd_i = 9; a.alu_dat_i = 32'h99;
    #1;
    n_chk++; if (b.alu_ready_o !== 1'b1 || b.stall_o !== 1'b0) begin n_fail++; $display("FAIL race_comb: got ready=%b stall=%b want 1/0", b.alu_ready_o, b.stall_o); end
    n_chk++; if (a.stall_o !== 1'b1) begin n_fail++; $display("FAIL race_waw_stall: got %b want 1", a.stall_o); end
    tick;
    idle;
    n_chk++; if (b.busy_o !== 32'h200 || b.wr_en_o !== 1'b1) begin n_fail++; $display("FAIL race_set_wins: got busy=%h wr=%b want 00000200/1", b.busy_o, b.wr_en_o); end
    n_chk++; if (a.busy_o !== 32'd0) begin n_fail++; $display("FAIL race_stalled_clear: got %h want 0", a.busy_o); end
    tick;
  endtask

  task test_random;
    bit [31:0] m_busy[2], m_dat[2], nb, adat, ldat;
    bit        m_palu[2], m_wr[2], ad[2], ld[2];
    bit [4:0]  m_rd[2], ard, lrd;
    bit        av, lv, es, ga, gl;
    logic        st[2], ar[2], lr[2], w[2];
    logic [31:0] bz[2], dd[2];
    logic [4:0]  ds[2];
    do_reset;
    m_busy = '{32'd0, 32'd0}; m_palu = '{1'b1, 1'b0};
    m_rd = '{5'd0, 5'd0}; m_dat = '{32'd0, 32'd0};
    ad = '{1'b1, 1'b1}; ld = '{1'b1, 1'b1};
    av = 0; lv = 0; ard = 0; lrd = 0; adat = 0; ldat = 0;
    for (int c = 0; c < 400; c++) begin
      // a request stays stable until both arbiters have accepted it
      if (ad[0] && ad[1]) begin
        av = $urandom_range(0, 2) != 0; ard = 5'($urandom_range(0, 7)); adat = $urandom;
        ad[0] = !av; ad[1] = !av;
      end
      if (ld[0] && ld[1]) begin
        lv = $urandom_range(0, 2) != 0; lrd = 5'($urandom_range(0, 7)); ldat = $urandom;
        ld[0] = !lv; ld[1] = !lv;
      end
      a.alu_valid_i = av; a.alu_rd_i = ard; a.alu_dat_i = adat;
      a.lsu_valid_i = lv; a.lsu_rd_i = lrd; a.lsu_dat_i = ldat;
      a.iss_valid_i = 1'($urandom_range(0, 1));
      a.iss_rd_i = 5'($urandom_range(0, 7));
      a.iss_rs1_i = 5'($urandom_range(0, 7));
      a.iss_rs2_i = 5'($urandom_range(0, 7));
      #1;
      st[0] = a.stall_o; st[1] = b.stall_o;
      ar[0] = a.alu_ready_o; ar[1] = b.alu_ready_o;
      lr[0] = a.lsu_ready_o; lr[1] = b.lsu_ready_o;
      for (int k = 0; k < 2; k++) begin
        es = a.iss_valid_i && ((a.iss_rs1_i != 0 && m_busy[k][a.iss_rs1_i]) ||
             (a.iss_rs2_i != 0 && m_busy[k][a.iss_rs2_i]) ||
             (k == 0 && a.iss_rd_i != 0 && m_busy[k][a.iss_rd_i]));
        ga = av && (!lv || m_palu[k]);
        gl = lv && !ga;
        n_chk++; if (st[k] !== es) begin n_fail++; $display("FAIL rnd_stall dut%0d cyc%0d: got %b want %b", k, c, st[k], es); end
        n_chk++; if ({ar[k], lr[k]} !== {ga, gl}) begin n_fail++; $display("FAIL rnd_ready dut%0d cyc%0d: got %b want %b", k, c, {ar[k], lr[k]}, {ga, gl}); end
        nb = m_busy[k];
        m_wr[k] = 0;
        if (ga || gl) begin
          m_rd[k] = ga ? ard : lrd;
          m_dat[k] = ga ? adat : ldat;
          m_wr[k] = m_rd[k] != 0;
          nb[m_rd[k]] = 0;
          m_palu[k] = gl;
        end
        if (a.iss_valid_i && !es && a.iss_rd_i != 0) nb[a.iss_rd_i] = 1;
        m_busy[k] = nb;
        if (ga) ad[k] = 1;
        if (gl) ld[k] = 1;
      end
      tick;
      bz[0] = a.busy_o; bz[1] = b.busy_o;
      w[0] = a.wr_en_o; w[1] = b.wr_en_o;
      ds[0] = a.reg_des_o; ds[1] = b.reg_des_o;
      dd[0] = a.reg_des_dat_o; dd[1] = b.reg_des_dat_o;
      for (int k = 0; k < 2; k++) begin
        n_chk++; if (bz[k] !== m_busy[k]) begin n_fail++; $display("FAIL rnd_busy dut%0d cyc%0d: got %h want %h", k, c, bz[k], m_busy[k]); end
        n_chk++; if (w[k] !== m_wr[k]) begin n_fail++; $display("FAIL rnd_wr dut%0d cyc%0d: got %b want %b", k, c, w[k], m_wr[k]); end
        if (m_wr[k]) begin
          n_chk++; if (ds[k] !== m_rd[k] || dd[k] !== m_dat[k]) begin n_fail++; $display("FAIL rnd_write dut%0d cyc%0d: got %0d/%h want %0d/%h", k, c, ds[k], dd[k], m_rd[k], m_dat[k]); end
        end
      end
    end
    idle;
    tick;
  endtask

  initial begin
    idle;
    test_reset;
    test_single_alu;
    test_collision;
    test_raw;
    test_x0_waw;
    test_race;
    test_random;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
